// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form Montgomery squaring core and its sequencer.
package redun_mont_pkg;

  localparam int unsigned T_LEN   = 16;
  localparam int unsigned REDUN_W = 32;

  typedef logic [REDUN_W-1:0] redun0_t;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRun,
    StDone,
    StFlush
  } seq_state_t;

  localparam int unsigned SEQ_TIMEOUT = 64;
  localparam int unsigned SEQ_WDOG_W  = $clog2(SEQ_TIMEOUT + 1);

endpackage

// File: rtl/redun_seq_wdog.sv
// No-progress watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the TIMEOUT-th enabled cycle occurs.
module redun_seq_wdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [W-1:0] cnt_q;

  assign timeout = en && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !timeout) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/redun_mont_seq.sv
// Seeds the free-running squaring core, counts its results and flushes it afterwards.
// Defining REDUN_SEQ_CHKPT_EN adds periodic checkpoint outputs (o_chk, o_chk_val).
module redun_mont_seq
  import redun_mont_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned TIMEOUT   = SEQ_TIMEOUT
`ifdef REDUN_SEQ_CHKPT_EN
  ,
  parameter int unsigned CHK_LOG   = 10
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  redun0_t          i_sq,
  input  logic [T_LEN-1:0] i_t,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output redun0_t          o_res,
  output logic [T_LEN-1:0] o_iter,
  output redun0_t          o_core_sq,
  output logic             o_core_val,
  output logic             o_core_rst,
  input  redun0_t          i_core_mul,
  input  logic             i_core_val
`ifdef REDUN_SEQ_CHKPT_EN
  ,
  output redun0_t          o_chk,
  output logic             o_chk_val
`endif
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);
  localparam int unsigned WdogW  = $clog2(TIMEOUT + 1);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_CYC - 1);

  seq_state_t       state_q;
  logic [FlushW-1:0] flush_cnt_q;
  logic [T_LEN-1:0] t_q, iter_q, iter_inc;
  logic             busy_q, done_q, err_q, seeded_q;
  logic             core_val_q, core_rst_q;
  redun0_t          res_q, core_sq_q;
  logic             wdog_clr, wdog_en, wdog_to;
`ifdef REDUN_SEQ_CHKPT_EN
  redun0_t          chk_q;
  logic             chk_val_q;
`endif

  assign iter_inc = iter_q + T_LEN'(1);
  assign wdog_en  = (state_q == StRun) && !i_core_val;
  assign wdog_clr = (state_q != StRun) || i_core_val;

  redun_seq_wdog #(
    .TIMEOUT(TIMEOUT),
    .W      (WdogW)
  ) u_wdog (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .timeout(wdog_to)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Reset lands in FLUSH so the core sees FLUSH_CYC reset cycles after release.
      state_q     <= StFlush;
      flush_cnt_q <= FlushInit;
      t_q         <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      seeded_q    <= 1'b0;
      res_q       <= '0;
      core_sq_q   <= '0;
      core_val_q  <= 1'b0;
      core_rst_q  <= 1'b1;
`ifdef REDUN_SEQ_CHKPT_EN
      chk_q       <= '0;
      chk_val_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef REDUN_SEQ_CHKPT_EN
      chk_val_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (i_t == '0) begin
              res_q    <= i_sq;
              seeded_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              t_q        <= i_t;
              iter_q     <= '0;
              seeded_q   <= 1'b1;
              core_sq_q  <= i_sq;
              core_val_q <= 1'b1;
              state_q    <= StSeed;
            end
          end
        end
        StSeed: begin
          core_val_q <= 1'b0;
          core_sq_q  <= '0;
          if (i_abort) begin
            state_q     <= StFlush;
            core_rst_q  <= 1'b1;
            flush_cnt_q <= FlushInit;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (i_abort) begin
            state_q     <= StFlush;
            core_rst_q  <= 1'b1;
            flush_cnt_q <= FlushInit;
          end else if (i_core_val) begin
            iter_q <= iter_inc;
`ifdef REDUN_SEQ_CHKPT_EN
            if ((iter_inc[CHK_LOG-1:0] == '0) && (iter_inc != '0)) begin
              chk_q     <= i_core_mul;
              chk_val_q <= 1'b1;
            end
`endif
            if (iter_inc == t_q) begin
              res_q   <= i_core_mul;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end else if (wdog_to) begin
            err_q       <= 1'b1;
            state_q     <= StFlush;
            core_rst_q  <= 1'b1;
            flush_cnt_q <= FlushInit;
          end
        end
        StDone: begin
          if (seeded_q) begin
            state_q     <= StFlush;
            core_rst_q  <= 1'b1;
            flush_cnt_q <= FlushInit;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            state_q    <= StIdle;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FlushW'(1);
          end
        end
        default: begin
          state_q     <= StFlush;
          core_rst_q  <= 1'b1;
          flush_cnt_q <= FlushInit;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_res      = res_q;
  assign o_iter     = iter_q;
  assign o_core_sq  = core_sq_q;
  assign o_core_val = core_val_q;
  assign o_core_rst = core_rst_q;
`ifdef REDUN_SEQ_CHKPT_EN
  assign o_chk      = chk_q;
  assign o_chk_val  = chk_val_q;
`endif

endmodule

// File: doc/redun_mont_seq.md
Name: redun_mont_seq

Overview:
- Sequencer for the redundant-form Montgomery squaring core (redun_mont), which free-runs once seeded.
- Accepts a start value and iteration count T, seeds the core with a one-cycle valid pulse, and counts result valids.
- Captures the T-th squaring, reports done, then holds the core in reset so it stops.
- Includes a no-progress watchdog and an abort path.

Parameters:
- FLUSH_CYC, 4: cycles o_core_rst is held high after completion, abort or timeout.
- TIMEOUT, 64: max cycles allowed between core valids (and from seed to first valid) before error.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_sq  in  redun0_t  start value, Montgomery form, redundant; sampled with i_start.
- i_t  in  T_LEN  number of squarings; sampled with i_start.
- i_abort  in  1  abort current run.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when o_res is valid.
- o_err  out  1  sticky watchdog error; cleared by next accepted i_start or by i_rst.
- o_res  out  redun0_t  final result, held until next accepted start.
- o_iter  out  T_LEN  squarings completed in the current run.
- o_core_sq  out  redun0_t  seed to core i_sq; zero except in SEED.
- o_core_val  out  1  seed valid to core i_val.
- o_core_rst  out  1  core reset.
- i_core_mul  in  redun0_t  core o_mul.
- i_core_val  in  1  core o_val.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_err=0, o_res=0, o_iter=0, o_core_val=0, o_core_sq=0, o_core_rst=1. State goes to FLUSH with its counter loaded, so the core gets FLUSH_CYC reset cycles after i_rst deasserts, then IDLE.
- States: IDLE, SEED, RUN, DONE, FLUSH.
- IDLE:
  - o_core_rst=0.
  - i_start with i_t==0: o_res<=i_sq, o_err<=0, go to DONE. The core is not seeded.
  - i_start with i_t!=0: latch i_t, clear o_iter, o_err and the watchdog, go to SEED.
- SEED:
  - Exactly one cycle with o_core_val=1 and o_core_sq = latched start value.
  - Next state RUN.
- RUN:
  - Each i_core_val increments o_iter and clears the watchdog.
  - When i_core_val arrives with o_iter==t-1: o_res<=i_core_mul, go to DONE.
  - i_core_val outside RUN is ignored.
- DONE:
  - One cycle; o_done=1.
  - Next state FLUSH if the core was seeded, else IDLE.
- FLUSH:
  - o_core_rst=1 for FLUSH_CYC cycles, then IDLE.
  - i_start is ignored.
- Watchdog:
  - Counts cycles in RUN without i_core_val.
  - On reaching TIMEOUT: o_err<=1, no o_done, go to FLUSH. o_res is unchanged.
- i_abort:
  - In SEED or RUN: go to FLUSH next cycle, no o_done, o_err unchanged.
  - Ignored in IDLE, DONE and FLUSH.
  - i_abort on the same cycle as the final i_core_val: abort wins, o_res is not updated.
- Start while busy: ignored, no queuing.
- o_iter wrap: impossible, since the count stops at t ≤ 2^T_LEN-1.
- i_rst mid-run: overrides everything; reset values apply and the core is flushed.

Optional Feature:
- Macro: REDUN_SEQ_CHKPT_EN.
- When defined:
  - Adds parameter CHK_LOG (default 10) and outputs o_chk (redun0_t) and o_chk_val (1).
  - In RUN, o_chk_val pulses with o_chk=i_core_mul on every i_core_val whose new o_iter value is a nonzero multiple of 2^CHK_LOG.
  - If that pulse coincides with the final result, both o_chk_val and o_done fire.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Add to redun_mont_pkg:
  - enum seq_state_t {IDLE, SEED, RUN, DONE, FLUSH};
  - a localparam for watchdog counter width, $clog2(TIMEOUT+1).
- redun0_t and T_LEN are reused from the package.
- One natural sub-module, redun_seq_wdog: watchdog counter with clear/enable inputs and a timeout output.

Test Plan:
- Start with i_t=1, seed a_ (mont form of 3) → exactly one o_core_val pulse; o_done when o_iter=1; from_redun(o_res)==fe_mul_mont(a_,a_); o_core_rst high for 4 cycles, then IDLE.
- i_t=0, i_sq=to_redun(5) → o_done 2 cycles after start, o_res==to_redun(5), o_core_val never asserted.
- Long run, 1000 iterations (T_LEN ≥ 10): from_mont(from_redun(o_res))==mod_sq(a,1000).
  - With REDUN_SEQ_CHKPT_EN and CHK_LOG=8: o_chk_val pulses at iterations 256, 512 and 768 only.
- i_abort asserted after 5 core valids → no o_done, o_iter==5, FLUSH entered; a fresh i_start with i_t=1 then completes correctly.
- Core stub stalls after 3 valids, TIMEOUT=64 → o_err=1 on the 64th idle cycle, no o_done; next i_start clears o_err.
- i_rst pulsed mid-RUN → all outputs at reset values, o_core_rst high, IDLE after FLUSH_CYC cycles; i_start during FLUSH is ignored.
